// File: rtl/stdp_array.sv
// rtl/stdp_array.sv - N_PRE LIF pre neurons driving one LIF post neuron through STDP-learned weights
// Optional build macro STDP_LEARN_GATE_EN adds input learn_en that gates all weight updates.
module stdp_array #(
    parameter int                        N_PRE      = 4,
    parameter int                        IN_W       = 8,
    parameter int                        STATE_W    = 9,
    parameter int                        W_W        = 4,
    parameter int                        W_INIT     = 8,
    parameter logic [N_PRE*STATE_W-1:0]  PRE_THR    = {9'd260, 9'd220, 9'd180, 9'd140},
    parameter int                        POST_THR   = 200,
    parameter int                        LEAK_SHIFT = 3,
    parameter int                        TW         = 4,
    parameter int                        WINDOW     = 8,
    parameter int                        DW_LTP     = 1,
    parameter int                        DW_LTD     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_W-1:0]        current,
`ifdef STDP_LEARN_GATE_EN
    input  logic                   learn_en,
`endif
    output logic [N_PRE-1:0]       spike_pre,
    output logic                   spike_post,
    output logic [N_PRE*W_W-1:0]   weights,
    output logic                   w_update
);

    // Wide enough for state + drive without overflow before clamping.
    localparam int EXT_W = ((IN_W > STATE_W) ? IN_W : STATE_W) + 2;
    localparam logic [STATE_W-1:0] S_MAX = {STATE_W{1'b1}};
    localparam logic [TW-1:0]      T_MAX = {TW{1'b1}};
    localparam int                 W_MAX = (1 << W_W) - 1;

    logic [STATE_W-1:0] pre_state_q [N_PRE];
    logic [STATE_W-1:0] pre_state_d [N_PRE];
    logic [N_PRE-1:0]   spike_pre_q, spike_pre_d;
    logic [STATE_W-1:0] post_state_q, post_state_d;
    logic               spike_post_q, spike_post_d;
    logic [TW-1:0]      tpre_q [N_PRE];
    logic [TW-1:0]      tpre_d [N_PRE];
    logic [TW-1:0]      tpost_q, tpost_d;
    logic [W_W-1:0]     w_q [N_PRE];
    logic [W_W-1:0]     w_d [N_PRE];
    logic               w_update_q, w_update_d;
    logic               learn;

`ifdef STDP_LEARN_GATE_EN
    assign learn = learn_en;
`else
    assign learn = 1'b1;
`endif

    // Leaky integration with clamping at the top of the state range.
    function automatic logic [STATE_W-1:0] lif_next(input logic [STATE_W-1:0] s,
                                                    input logic [EXT_W-1:0]   drive);
        logic [EXT_W-1:0] t;
        t = EXT_W'(s) - EXT_W'(s >> LEAK_SHIFT) + drive;
        if (t > EXT_W'(S_MAX)) return S_MAX;
        return t[STATE_W-1:0];
    endfunction

    // Trace counts cycles since the last spike and parks at all-ones.
    function automatic logic [TW-1:0] trace_next(input logic spk, input logic [TW-1:0] t);
        if (spk) return TW'(1);
        if (t == T_MAX) return T_MAX;
        return t + TW'(1);
    endfunction

    // Next-state for neurons, traces and weights.
    always_comb begin
        logic [EXT_W-1:0] post_sum;
        post_sum   = '0;
        w_update_d = 1'b0;
        for (int i = 0; i < N_PRE; i++) begin
            if (pre_state_q[i] >= PRE_THR[i*STATE_W +: STATE_W]) begin
                pre_state_d[i] = '0;
                spike_pre_d[i] = 1'b1;
            end else begin
                pre_state_d[i] = lif_next(pre_state_q[i], EXT_W'(current));
                spike_pre_d[i] = 1'b0;
            end
            if (spike_pre_q[i]) post_sum = post_sum + EXT_W'(w_q[i]);
            tpre_d[i] = trace_next(spike_pre_q[i], tpre_q[i]);

            // Potentiation wins over depression when pre and post coincide.
            w_d[i] = w_q[i];
            if (learn) begin
                if (spike_post_q && (spike_pre_q[i] || (tpre_q[i] <= TW'(WINDOW)))) begin
                    if (int'(w_q[i]) + DW_LTP > W_MAX) w_d[i] = W_W'(W_MAX);
                    else                               w_d[i] = w_q[i] + W_W'(DW_LTP);
                end else if (spike_pre_q[i] && (tpost_q <= TW'(WINDOW))) begin
                    if (int'(w_q[i]) < DW_LTD) w_d[i] = '0;
                    else                       w_d[i] = w_q[i] - W_W'(DW_LTD);
                end
            end
            if (w_d[i] != w_q[i]) w_update_d = 1'b1;
        end
        if (post_sum > EXT_W'(S_MAX)) post_sum = EXT_W'(S_MAX);

        if (post_state_q >= STATE_W'(POST_THR)) begin
            post_state_d = '0;
            spike_post_d = 1'b1;
        end else begin
            post_state_d = lif_next(post_state_q, post_sum);
            spike_post_d = 1'b0;
        end
        tpost_d = trace_next(spike_post_q, tpost_q);
    end

    // State registers; reset clears activity and forgets all spike history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PRE; i++) begin
                pre_state_q[i] <= '0;
                tpre_q[i]      <= T_MAX;
                w_q[i]         <= W_W'(W_INIT);
            end
            spike_pre_q  <= '0;
            post_state_q <= '0;
            spike_post_q <= 1'b0;
            tpost_q      <= T_MAX;
            w_update_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_PRE; i++) begin
                pre_state_q[i] <= pre_state_d[i];
                tpre_q[i]      <= tpre_d[i];
                w_q[i]         <= w_d[i];
            end
            spike_pre_q  <= spike_pre_d;
            post_state_q <= post_state_d;
            spike_post_q <= spike_post_d;
            tpost_q      <= tpost_d;
            w_update_q   <= w_update_d;
        end
    end

    // Pack weights onto the flat output bus.
    always_comb begin
        weights = '0;
        for (int i = 0; i < N_PRE; i++) weights[i*W_W +: W_W] = w_q[i];
    end

    assign spike_pre  = spike_pre_q;
    assign spike_post = spike_post_q;
    assign w_update   = w_update_q;

endmodule

// File: tb/tb_stdp_array.sv
// tb/tb_stdp_array.sv - randomized check of stdp_array against an arithmetic reference model
module tb_stdp_array;

    localparam int N        = 4;
    localparam int POST_THR = 40;
    localparam int WINDOW   = 8;

    logic         clk = 1'b0;
    logic         clk_run = 1'b0;
    logic         rst;
    logic [7:0]   current;
`ifdef STDP_LEARN_GATE_EN
    logic         learn_en = 1'b1;
`endif
    logic [N-1:0] spike_pre;
    logic         spike_post;
    logic [15:0]  weights;
    logic         w_update;

    int checks = 0;
    int errors = 0;

    stdp_array #(.POST_THR(POST_THR)) dut (
        .clk(clk),
        .rst(rst),
        .current(current),
`ifdef STDP_LEARN_GATE_EN
        .learn_en(learn_en),
`endif
        .spike_pre(spike_pre),
        .spike_post(spike_post),
        .weights(weights),
        .w_update(w_update)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain integers, one call per clock edge.
    int m_st[N], m_spk[N], m_tpre[N], m_w[N];
    int m_pst, m_pspk, m_tpost, m_upd;
    int ltp_cnt = 0, ltd_cnt = 0;

    function automatic int thr_of(input int i);
        case (i)
            0: return 140;
            1: return 180;
            2: return 220;
            default: return 260;
        endcase
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_spk[i] = 0; m_tpre[i] = 15; m_w[i] = 8;
        end
        m_pst = 0; m_pspk = 0; m_tpost = 15; m_upd = 0;
    endtask

    task automatic model_step(input int cur);
        int n_st[N], n_spk[N], n_t[N], n_w[N];
        int sum, n_pst, n_pspk, upd;
        sum = 0;
        upd = 0;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] >= thr_of(i)) begin n_st[i] = 0; n_spk[i] = 1; end
            else begin n_st[i] = imin(m_st[i] - m_st[i] / 8 + cur, 511); n_spk[i] = 0; end
            if (m_spk[i] != 0) sum += m_w[i];
            n_t[i] = (m_spk[i] != 0) ? 1 : imin(m_tpre[i] + 1, 15);
            n_w[i] = m_w[i];
            if (m_pspk != 0 && (m_spk[i] != 0 || m_tpre[i] <= WINDOW)) begin
                n_w[i] = imin(m_w[i] + 1, 15);
                ltp_cnt++;
            end else if (m_spk[i] != 0 && m_tpost <= WINDOW) begin
                n_w[i] = (m_w[i] > 0) ? m_w[i] - 1 : 0;
                ltd_cnt++;
            end
            if (n_w[i] != m_w[i]) upd = 1;
        end
        sum = imin(sum, 511);
        if (m_pst >= POST_THR) begin n_pst = 0; n_pspk = 1; end
        else begin n_pst = imin(m_pst - m_pst / 8 + sum, 511); n_pspk = 0; end
        m_tpost = (m_pspk != 0) ? 1 : imin(m_tpost + 1, 15);
        for (int i = 0; i < N; i++) begin
            m_st[i] = n_st[i]; m_spk[i] = n_spk[i]; m_tpre[i] = n_t[i]; m_w[i] = n_w[i];
        end
        m_pst = n_pst; m_pspk = n_pspk; m_upd = upd;
    endtask

    task automatic compare_all(input string tag);
        int sp, wp;
        sp = 0;
        wp = 0;
        for (int i = 0; i < N; i++) begin
            sp |= m_spk[i] << i;
            wp |= m_w[i] << (4 * i);
        end
        check({tag, ".spike_pre"}, 32'(spike_pre), 32'(sp));
        check({tag, ".spike_post"}, 32'(spike_post), 32'(m_pspk));
        check({tag, ".weights"}, 32'(weights), 32'(wp));
        check({tag, ".w_update"}, 32'(w_update), 32'(m_upd));
    endtask

    task automatic step(input int cur, input string tag);
        current = 8'(cur);
        @(posedge clk);
        model_step(cur);
        #1;
        compare_all(tag);
    endtask

    // Async reset raised between edges, checked before the next edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("rst_held");
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int upd_seen;
        rst = 1'b0;
        current = 8'd0;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_weights", 32'(weights), 32'h8888);
        check("rst_spike_pre", 32'(spike_pre), 32'h0);
        check("rst_spike_post", 32'(spike_post), 32'h0);
        check("rst_w_update", 32'(w_update), 32'h0);
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        upd_seen = 0;
        for (int c = 0; c < 1000; c++) begin
            step(0, "idle");
            if (w_update) upd_seen++;
        end
        check("idle_no_update", 32'(upd_seen), 32'h0);
        check("idle_weights", 32'(weights), 32'h8888);

        async_reset();
        step(255, "drive_e1");
        check("e1_spike_pre", 32'(spike_pre), 32'h0);
        step(255, "drive_e2");
        check("e2_spike_pre0", 32'(spike_pre[0]), 32'h1);
        for (int c = 0; c < 2000; c++) step(255, "drive");

        for (int seg = 0; seg < 20; seg++) begin
            int cur, len;
            cur = $urandom_range(0, 255);
            len = $urandom_range(50, 300);
            for (int c = 0; c < len; c++) step(cur, "rand");
            if ($urandom_range(0, 3) == 0) async_reset();
        end

        check("ltp_exercised", 32'(ltp_cnt > 0), 32'h1);
        check("ltd_exercised", 32'(ltd_cnt > 0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
